// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the write-side FIFO arbiter and its round-robin
//   picker: FSM state encoding, default data width, debug counter width and
//   a modulo-increment helper used for the rotating priority pointer.
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int WR_COUNT_W     = 16;

    // Increment an index that wraps at an arbitrary modulus (not necessarily
    // a power of two).
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_rr_pick
//   Purely combinational round-robin picker. Returns the first requester at
//   or after ptr, searching ptr, ptr+1, ... modulo NUM_REQ.
//
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   ID_W     highest-priority index for this search
//   idx    out  ID_W     index of the winning requester (ptr when none)
//   valid  out  1        at least one requester was found
// ---------------------------------------------------------------------------
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    always_comb begin
        int cand;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, so no path can leave it unassigned and
        // infer a latch.
        idx   = ptr;
        valid = 1'b0;
        cand  = int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid && req[ID_W'(cand)]) begin
                idx   = ID_W'(cand);
                valid = 1'b1;
            end
            cand = wrap_inc(cand, NUM_REQ);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single async-FIFO write port between
//   NUM_REQ producers in the wclk domain. An owner is granted in IDLE and
//   then streams up to BURST_MAX words; the FIFO full flag stalls the burst
//   without ending it. The handshake is combinational so that wen is never
//   issued against a stale full.
//
// Ports:
//   wclk      in   1                   write-domain clock (rising edge)
//   rst       in   1                   asynchronous active-high reset
//   en        in   1                   enable; 0 blocks grants, ends bursts
//   req       in   NUM_REQ             per-producer word-valid
//   din_flat  in   NUM_REQ*DATA_WIDTH  producer words, i at [i*DW +: DW]
//   full      in   1                   FIFO full (wclk domain)
//   ack       out  NUM_REQ             one-hot word-consumed strobe
//   wen       out  1                   FIFO write enable
//   dout      out  DATA_WIDTH          FIFO write data
//   busy      out  1                   a burst is open
//   owner     out  ID_W                current or last owner
//   wr_count  out  WR_COUNT_W          words written, wraps
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_flat,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wen,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          busy,
    output logic [ID_W-1:0]               owner,
    output logic [WR_COUNT_W-1:0]         wr_count
);

    // One extra bit so the counter can reach BURST_MAX after the last beat
    // without wrapping, even when BURST_MAX is a power of two.
    localparam int                BEAT_W    = $clog2(BURST_MAX) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);

    arb_state_e             state, state_nxt;
    logic [ID_W-1:0]        ptr, ptr_nxt;
    logic [ID_W-1:0]        owner_q, owner_nxt;
    logic [BEAT_W-1:0]      beat_cnt, beat_nxt;
    logic [WR_COUNT_W-1:0]  wr_cnt_q;

    logic [ID_W-1:0]        pick_idx;
    logic                   pick_valid;
    logic                   owner_req;
    logic                   accept;
    logic                   last_beat;
    logic                   burst_end;

    fifo_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // ---------------------------------------------------------------------
    // Combinational handshake: a word moves only while the burst is open,
    // the owner still has data, the arbiter is enabled and the FIFO has room.
    // ---------------------------------------------------------------------
    assign owner_req = req[owner_q];
    assign accept    = (state == BURST) && en && owner_req && !full;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign burst_end = !en || !owner_req || (accept && last_beat);

    always_comb begin
        ack          = '0;
        ack[owner_q] = accept;
    end

    assign wen      = accept;
    assign dout     = din_flat[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
    assign busy     = (state == BURST);
    assign owner    = owner_q;
    assign wr_count = wr_cnt_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner_q;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (en && pick_valid) begin
                    owner_nxt = pick_idx;
                    beat_nxt  = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_nxt = beat_cnt + BEAT_W'(1);
                end
                // A single exit covers every combination of last beat,
                // request drop and disable; the finishing owner becomes
                // lowest priority for the next search.
                if (burst_end) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ID_W'(wrap_inc(int'(owner_q), NUM_REQ));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge wclk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner_q  <= '0;
            beat_cnt <= '0;
            wr_cnt_q <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner_q  <= owner_nxt;
            beat_cnt <= beat_nxt;
            if (accept) begin
                wr_cnt_q <= wr_cnt_q + WR_COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed self-checking bench for fifo_wr_arbiter (4 producers, 32-bit
//   words, bursts of 8). Inputs change on the falling edge, outputs are read
//   1 ns later; producers advance their word on the rising edge after an ack.
//   Edge numbers c count rising edges after the latest reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic           wclk;
    logic           rst;
    logic           en;
    logic [NR-1:0]  req;
    logic [NR*DW-1:0] din_flat;
    logic           full;
    logic [NR-1:0]  ack;
    logic           wen;
    logic [DW-1:0]  dout;
    logic           busy;
    logic [1:0]     owner;
    logic [15:0]    wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] data_mem [NR][64];
    int            prod_idx [NR] = '{default: 0};
    int            sb_idx   [NR] = '{default: 0};
    logic [NR-1:0] ack_seen = '0;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_MAX  (8)
    ) dut (
        .wclk     (wclk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .din_flat (din_flat),
        .full     (full),
        .ack      (ack),
        .wen      (wen),
        .dout     (dout),
        .busy     (busy),
        .owner    (owner),
        .wr_count (wr_count)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Producer model: each presents its current word and moves on after ack.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            din_flat[i*DW +: DW] = data_mem[i][prod_idx[i][5:0]];
        end
    end

    always @(posedge wclk) begin
        for (int i = 0; i < NR; i++) begin
            if (ack_seen[i]) prod_idx[i] <= prod_idx[i] + 1;
        end
    end

    // Scoreboard: every FIFO write must be the next word of that producer.
    always @(negedge wclk) begin
        #3;
        ack_seen = ack;
        if (!rst && wen) begin
            check("sb_data", 64'(dout), 64'(data_mem[owner][sb_idx[owner][5:0]]));
            check("ack_onehot", 64'(ack), 64'(4'b0001 << owner));
            check("wen_vs_full", 64'(full), 64'd0);
            sb_idx[owner]++;
        end
    end

    task automatic do_reset();
        @(negedge wclk);
        rst  = 1'b1;
        req  = 4'b1111;
        en   = 1'b1;
        full = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge wclk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 64; k++)
                data_mem[i][k] = $urandom;
        rst  = 1'b1;
        en   = 1'b1;
        full = 1'b0;
        req  = '0;
        #1 req = 4'b1111;

        // ---- Reset: outputs quiet while rst is high ----
        for (int k = 0; k < 4; k++) begin
            @(negedge wclk); #1;
            check("rst_ack",  64'(ack),  64'd0);
            check("rst_wen",  64'(wen),  64'd0);
            check("rst_busy", 64'(busy), 64'd0);
        end
        @(negedge wclk);               // t = 50 ns
        rst = 1'b0;
        #1;
        check("idle_wen",   64'(wen),      64'd0);
        check("idle_owner", 64'(owner),    64'd0);
        check("idle_cnt",   64'(wr_count), 64'd0);

        // ---- Rotation: 9 edges per burst (1 grant + 8 words) ----
        for (int c = 1; c <= 37; c++) begin
            int r, exp_cnt;
            logic exp_busy;
            @(negedge wclk); #1;
            r        = c % 9;
            exp_busy = (r != 0);
            exp_cnt  = 8 * (c / 9) + ((r >= 1) ? r - 1 : 0);
            check("rot_busy",  64'(busy),     64'(exp_busy));
            check("rot_wen",   64'(wen),      64'(exp_busy));
            check("rot_owner", 64'(owner),    64'(((c - 1) / 9) % 4));
            check("rot_cnt",   64'(wr_count), 64'(exp_cnt));
        end

        // ---- Full stall on owner 1 after its words 0..3, then early drop ----
        do_reset();
        for (int c = 1; c <= 28; c++) begin
            @(negedge wclk);
            full = (c >= 14 && c <= 18);
            if (c == 26) req = 4'b1000;
            #1;
            if (c >= 14 && c <= 18) begin
                check("stall_wen",   64'(wen),      64'd0);
                check("stall_ack",   64'(ack),      64'd0);
                check("stall_owner", 64'(owner),    64'd1);
                check("stall_busy",  64'(busy),     64'd1);
                check("stall_cnt",   64'(wr_count), 64'd12);
            end
            if (c == 19) check("resume_wen", 64'(wen), 64'd1);
            if (c == 23) begin
                check("stall_end_cnt",  64'(wr_count), 64'd16);
                check("stall_end_busy", 64'(busy),     64'd0);
            end
            if (c == 24) check("next_owner2", 64'(owner), 64'd2);
            if (c == 26) begin
                check("drop_wen", 64'(wen),      64'd0);
                check("drop_cnt", 64'(wr_count), 64'd18);
            end
            if (c == 27) begin
                check("drop_busy",  64'(busy),     64'd0);
                check("drop_owner", 64'(owner),    64'd2);
                check("drop_words", 64'(wr_count), 64'd18);
            end
            if (c == 28) begin
                check("drop_next_owner", 64'(owner), 64'd3);
                check("drop_next_busy",  64'(busy),  64'd1);
                check("drop_next_wen",   64'(wen),   64'd1);
            end
        end

        // ---- Enable dropped mid-burst of owner 0 ----
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            @(negedge wclk);
            if (c == 3) en = 1'b0;
            if (c == 6) en = 1'b1;
            #1;
            if (c == 3) begin
                check("en_ack",  64'(ack),  64'd0);
                check("en_wen",  64'(wen),  64'd0);
            end
            if (c >= 4 && c <= 6) begin
                check("en_idle_busy", 64'(busy),     64'd0);
                check("en_idle_cnt",  64'(wr_count), 64'd2);
            end
            if (c == 7) begin
                check("en_next_owner", 64'(owner), 64'd1);
                check("en_next_busy",  64'(busy),  64'd1);
            end
        end

        // ---- wr_count wrap, then asynchronous reset mid-burst ----
        // Burst 8191 (owner 3) is granted at edge 73720; its sixth word at
        // edge 73726 brings the total to 0xFFFE.
        do_reset();
        for (int c = 1; c <= 73730; c++) begin
            @(negedge wclk); #1;
            if (c == 73726) check("wrap_fffe", 64'(wr_count), 64'h0000_FFFE);
            if (c == 73727) begin
                check("wrap_ffff",  64'(wr_count), 64'h0000_FFFF);
                check("wrap_owner", 64'(owner),    64'd3);
            end
            if (c == 73728) begin
                check("wrap_zero", 64'(wr_count), 64'd0);
                check("wrap_busy", 64'(busy),     64'd0);
            end
            if (c == 73729) check("wrap_owner0", 64'(owner), 64'd0);
            if (c == 73730) begin
                check("mid_wen",  64'(wen),  64'd1);
                check("mid_busy", 64'(busy), 64'd1);
                rst = 1'b1;
                #1;
                check("async_busy", 64'(busy),     64'd0);
                check("async_wen",  64'(wen),      64'd0);
                check("async_ack",  64'(ack),      64'd0);
                check("async_cnt",  64'(wr_count), 64'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
